my_mul3232u: RTL and testbench



---
 rtl/my_mul3232u.sv | 107 ++++++++++
 tb/tb_my_mul3232u.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/my_mul3232u.sv
// Sequential unsigned 32x32->64 shift-add multiplier with toggle request/acknowledge handshake.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module my_mul3232u (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    input  logic        run_in,
    output logic        run_out
);

    typedef enum logic {
        S_IDLE,
        S_ITER
    } state_t;

    state_t      state_q,   state_d;
    logic [63:0] acc_q,     acc_d;
    logic [63:0] mcand_q,   mcand_d;
    logic [31:0] mplier_q,  mplier_d;
    logic [5:0]  count_q,   count_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic        run_out_q, run_out_d;

    logic pending;
    logic iter_done;

    assign pending = run_in ^ run_out_q;

    // count never exceeds 32, so bit 5 alone marks the final iteration
`ifdef MUL_EARLY_EXIT_EN
    assign iter_done = count_q[5] || (mplier_q == '0);
`else
    assign iter_done = count_q[5];
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        run_out_d = run_out_q;

        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    acc_d    = '0;
                    mcand_d  = {32'd0, a};
                    mplier_d = b;
                    count_d  = '0;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                if (!pending) begin
                    state_d = S_IDLE;
                end else if (iter_done) begin
                    hi_d      = acc_q[63:32];
                    lo_d      = acc_q[31:0];
                    run_out_d = ~run_out_q;
                    state_d   = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            run_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            run_out_q <= run_out_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign run_out = run_out_q;

endmodule

// File: tb/tb_my_mul3232u.sv
// Scoreboard bench for my_mul3232u; expected latency follows MUL_EARLY_EXIT_EN when defined.
module tb_my_mul3232u;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        run_in;
    logic        run_out;

    my_mul3232u dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .run_in  (run_in),
        .run_out (run_out)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        prev_ro = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int unsigned lat(input logic [31:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int unsigned msb = 0;
        if (bv == 32'd0) return 1;
        for (int i = 0; i < 32; i++) if (bv[i]) msb = i;
        return 2 + msb;
`else
        return 33;
`endif
    endfunction

    // Monitor: every acknowledge toggle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_ro = run_out;
        end else if (run_out !== prev_ro) begin
            prev_ro = run_out;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: run_out=%0b at cycle %0d, expected no toggle", run_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at negedge+1: the next posedge is E0.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        a      = av;
        b      = bv;
        run_in = ~run_in;
        e.hi   = ehi;
        e.lo   = elo;
        e.due  = cyc + 1 + lat(bv);
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name);
        logic start;
        bit   seen;
        start = run_out;
        seen  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (run_out !== start) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: run_out=%0b, expected toggle within 100 cycles", name, run_out);
        end
    endtask

    initial begin
        int unsigned abort_at;
        reset  = 1'b1;
        run_in = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_run_out", {63'd0, run_out}, 64'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;

        issue(32'd3, 32'd5, 32'd0, 32'd15);
        wait_ack("mul_3x5");

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_ack("mul_max");

        // second request issued in the same cycle the first acknowledge is seen
        issue(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        wait_ack("mul_2p16");
        issue(32'd7, 32'd0, 32'd0, 32'd0);
        wait_ack("mul_b2b_zero");

        issue(32'd6, 32'd7, 32'd0, 32'd42);
        @(negedge clk);
        #1;
        a = 32'd0;
        wait_ack("mul_opchange");

`ifdef MUL_EARLY_EXIT_EN
        abort_at = 2;
`else
        abort_at = 10;
`endif
        a      = 32'd2;
        b      = 32'd9;
        run_in = ~run_in;
        repeat (abort_at + 1) @(negedge clk);
        #1;
        run_in = ~run_in;
        repeat (40) @(negedge clk);
        #1;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd42);
        chk("abort_run_out", {63'd0, run_out}, 64'd1);

        issue(32'd3, 32'd5, 32'd0, 32'd15);
        repeat (3) @(negedge clk);
        #1;
        reset  = 1'b1;
        run_in = 1'b0;
        sb.delete();
        #1;
        chk("midop_reset_run_out", {63'd0, run_out}, 64'd0);
        chk("midop_reset_hi", {32'd0, hi}, 64'd0);
        chk("midop_reset_lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;

        issue(32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
        wait_ack("mul_post_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
